// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic bitstream sources: FSM encoding and
// the default feedback polynomial for 16-bit Galois LFSRs.
package stoch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal length in right-shift Galois form
  localparam logic [15:0] TAPS_W16 = 16'hB400;

endpackage

// File: rtl/stoch_lfsr.sv
// Right-shifting Galois LFSR used as the random source of stochastic encoders.
// A zero seed is forced to 1 so the register can never lock up.
module stoch_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = stoch_pkg::TAPS_W16,
  parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] SEED_SAFE = (SEED == '0) ? WIDTH'(1) : SEED;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SEED_SAFE;
    end else if (en) begin
      state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
    end
  end

endmodule

// File: rtl/stoch_generator.sv
// Unipolar stochastic encoder: emits `length` bits with P(1) = value/(2^WIDTH-1)
// by comparing a maximal-length LFSR against the value captured at start.
module stoch_generator
  import stoch_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               LEN_WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED      = 16'h0001
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     value,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 out,
  output logic                 out_valid,
  output logic                 done
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                 state_p0;
  state_t                 state_nx;
  logic [WIDTH-1:0]       value_p0;
  logic [LEN_WIDTH-1:0]   rem_p0;
  logic [WIDTH-1:0]       lfsr;
  logic [WIDTH-1:0]       cmp_val;
  logic                   accept;
  logic                   last;
  logic                   emit;
  logic                   bit_nx;
  logic                   done_nx;

  stoch_lfsr #(
    .WIDTH(WIDTH),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .en   (emit),
    .state(lfsr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0 <= ST_IDLE;
    end else begin
      state_p0 <= state_nx;
    end
  end

  // A length-1 stream is fully emitted on the accepting edge, so it never enters RUN.
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      ST_IDLE: if (accept && (length != LEN_ONE)) state_nx = ST_RUN;
      ST_RUN:  if (last || abort)                 state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // The accepting edge already produces the first bit, using the live value input.
  always_comb begin
    accept  = (state_p0 == ST_IDLE) && start && (length != '0);
    last    = (state_p0 == ST_RUN) && (rem_p0 == LEN_ONE);
    emit    = accept || ((state_p0 == ST_RUN) && (last || !abort));
    cmp_val = (state_p0 == ST_IDLE) ? value : value_p0;
    bit_nx  = emit && (lfsr <= cmp_val);
    done_nx = ((state_p0 == ST_IDLE) && start && (length <= LEN_ONE)) || last;
    busy    = (state_p0 == ST_RUN);
  end

  // Output and stream-bookkeeping registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      value_p0  <= '0;
      rem_p0    <= '0;
    end else begin
      out       <= bit_nx;
      out_valid <= emit;
      done      <= done_nx;
      if (accept) begin
        value_p0 <= value;
        rem_p0   <= length - LEN_ONE;
      end else if (emit) begin
        rem_p0   <= rem_p0 - LEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_stoch_generator.sv
// Directed bench for stoch_generator: a table of streams checked against a
// reference LFSR model, plus hand-written reset sequences.
module tb_stoch_generator;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        abort;
  logic [15:0] value;
  logic [31:0] length;
  logic        busy;
  logic        out;
  logic        out_valid;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [15:0] mdl;

  always #5 CLK = ~CLK;

  stoch_generator dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .abort    (abort),
    .value    (value),
    .length   (length),
    .busy     (busy),
    .out      (out),
    .out_valid(out_valid),
    .done     (done)
  );

  typedef struct {
    logic [15:0] v;
    logic [31:0] n;
    int          abort_at;
    bit          start_mid;
    int          exp_valid;
    int          exp_ones;
    int          exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mdl_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    mdl = 16'h0001;
  endtask

  task automatic run_stream(input logic [15:0] v, input logic [31:0] n,
                            input int abort_at, input bit start_mid,
                            output int nvalid, output int nones, output int nmis,
                            output int ndone, output int done_bad, output int post_bad,
                            output logic [63:0] sig);
    bit ab_done = 0;
    bit mid_done = 0;
    nvalid = 0; nones = 0; nmis = 0; ndone = 0; done_bad = 0; post_bad = 0; sig = '0;
    @(negedge CLK);
    start = 1'b1; value = v; length = n;
    for (int c = 0; c < int'(n) + 4; c++) begin
      @(negedge CLK);
      start = 1'b0;
      abort = 1'b0;
      if (out_valid) begin
        nvalid++;
        if (out !== (mdl <= v)) nmis++;
        if (out) nones++;
        sig = {sig[62:0], out};
        mdl = mdl_step(mdl);
      end else if (out !== 1'b0) begin
        nmis++;
      end
      if (done) begin
        ndone++;
        if (busy !== 1'b0) done_bad++;
        else if (n == 0 && out_valid !== 1'b0) done_bad++;
        else if (n != 0 && !(out_valid === 1'b1 && nvalid == int'(n))) done_bad++;
      end else if (busy && ndone > 0) begin
        post_bad++;
      end
      if (n == 0 && busy) post_bad++;
      if (abort_at > 0 && !ab_done && nvalid == abort_at) begin
        abort = 1'b1; ab_done = 1;
      end
      if (start_mid && !mid_done && nvalid == 3) begin
        start = 1'b1; value = ~v; length = 32'd5; mid_done = 1;
      end
    end
    abort = 1'b0;
  endtask

  int nvalid, nones, nmis, ndone, done_bad, post_bad;
  logic [63:0] sig, sig_a;

  initial begin
    vecs[0] = '{16'h8000, 32'd65535, -1, 0, 65535, 32768, 1};
    vecs[1] = '{16'h0000, 32'd100,   -1, 0, 100,   0,     1};
    vecs[2] = '{16'hFFFF, 32'd100,   -1, 0, 100,   100,   1};
    vecs[3] = '{16'h0000, 32'd0,     -1, 0, 0,     0,     1};
    vecs[4] = '{16'h4000, 32'd200,   -1, 1, 200,   -1,    1};
    vecs[5] = '{16'h1234, 32'd50,    10, 0, 10,    -1,    0};
    vecs[6] = '{16'h1234, 32'd50,    -1, 0, 50,    -1,    1};
    vecs[7] = '{16'hFFFF, 32'd1,     -1, 0, 1,     1,     1};
    vecs[8] = '{16'h0001, 32'd3,     -1, 0, 3,     -1,    1};

    RST = 1'b1; start = 1'b0; abort = 1'b0; value = '0; length = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mdl = 16'h0001;
    @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 9; i++) begin
      run_stream(vecs[i].v, vecs[i].n, vecs[i].abort_at, vecs[i].start_mid,
                 nvalid, nones, nmis, ndone, done_bad, post_bad, sig);
      if (vecs[i].abort_at > 0)
        chk($sformatf("v%0d_abort_len", i), (nvalid == 10 || nvalid == 11) ? 1 : 0, 1);
      else
        chk($sformatf("v%0d_valid", i), nvalid, vecs[i].exp_valid);
      if (vecs[i].exp_ones >= 0)
        chk($sformatf("v%0d_ones", i), nones, vecs[i].exp_ones);
      chk($sformatf("v%0d_bits", i), nmis, 0);
      chk($sformatf("v%0d_done_cnt", i), ndone, vecs[i].exp_done);
      chk($sformatf("v%0d_done_align", i), done_bad, 0);
      chk($sformatf("v%0d_busy_after", i), post_bad, 0);
    end

    // Mid-stream reset clears outputs and rewinds the LFSR
    @(negedge CLK);
    start = 1'b1; value = 16'h5555; length = 32'd40;
    @(negedge CLK);
    start = 1'b0;
    repeat (14) @(negedge CLK);
    chk("mid_busy_before", busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mdl = 16'h0001;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);

    run_stream(16'h5555, 32'd64, -1, 0, nvalid, nones, nmis, ndone, done_bad, post_bad, sig_a);
    chk("seq_a_bits", nmis, 0);
    chk("seq_a_valid", nvalid, 64);
    pulse_reset();
    run_stream(16'h5555, 32'd64, -1, 0, nvalid, nones, nmis, ndone, done_bad, post_bad, sig);
    chk("seq_b_bits", nmis, 0);
    chk("seq_repeat", sig, sig_a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
